// File: rtl/eth_tx_pkt_fifo.sv
// Store-and-forward TX packet FIFO with cut-through fallback for oversize frames.
// Optional statistics counters are enabled with `define TX_FIFO_STATS_EN.
module eth_tx_pkt_fifo #(
    parameter int DW    = 512,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [DW-1:0]            axis_in_tdata,
    input  logic                     axis_in_tlast,
    input  logic                     axis_in_tvalid,
    output logic                     axis_in_tready,
    output logic [DW-1:0]            axis_out_tdata,
    output logic                     axis_out_tlast,
    output logic                     axis_out_tvalid,
    input  logic                     axis_out_tready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [$clog2(DEPTH):0]   pkt_count
`ifdef TX_FIFO_STATS_EN
    ,
    output logic [31:0]              stat_frames_in,
    output logic [31:0]              stat_frames_out,
    output logic [31:0]              stat_cut_thru
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [DW:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, pkt_cnt;
    logic          started, cut_thru, out_vld;
    logic          full, empty, wr_en, rd_en, wr_last, rd_last, cut_set;
    logic [AW:0]   level, lvl_after_rd, pkt_after_rd;
    logic          cut_after_rd, vld_nxt;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

    assign axis_in_tready  = started & ~full;
    assign axis_out_tvalid = out_vld;
    // Head entry is presented directly; it cannot change while tvalid waits for tready.
    assign {axis_out_tlast, axis_out_tdata} = mem[rd_ptr[AW-1:0]];
    assign fifo_level = level;
    assign pkt_count  = pkt_cnt;

    assign wr_en   = axis_in_tvalid & axis_in_tready;
    assign rd_en   = out_vld & axis_out_tready;
    assign wr_last = wr_en & axis_in_tlast;
    assign rd_last = rd_en & axis_out_tlast;
    assign cut_set = full && (pkt_cnt == '0) && !cut_thru;

    // tvalid looks at the state after this edge's read but before this edge's
    // write, so a newly stored beat becomes visible one cycle later.
    assign lvl_after_rd = level - (AW+1)'(rd_en);
    assign pkt_after_rd = pkt_cnt - (AW+1)'(rd_last);
    assign cut_after_rd = cut_thru & ~rd_last;
    assign vld_nxt      = (lvl_after_rd != '0) && ((pkt_after_rd != '0) || cut_after_rd);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {axis_in_tlast, axis_in_tdata};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            started  <= 1'b0;
            cut_thru <= 1'b0;
            out_vld  <= 1'b0;
        end else begin
            started <= 1'b1;
            out_vld <= vld_nxt;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_last, rd_last})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
            // A full FIFO holding no complete frame can only make progress by streaming.
            if (rd_last)      cut_thru <= 1'b0;
            else if (cut_set) cut_thru <= 1'b1;
        end
    end

`ifdef TX_FIFO_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_frames_in  <= '0;
            stat_frames_out <= '0;
            stat_cut_thru   <= '0;
        end else begin
            if (wr_last) stat_frames_in  <= stat_frames_in + 32'd1;
            if (rd_last) stat_frames_out <= stat_frames_out + 32'd1;
            if (cut_set && !rd_last) stat_cut_thru <= stat_cut_thru + 32'd1;
        end
    end
`endif

    logic unused_empty;
    assign unused_empty = empty;

endmodule

// File: tb/tb_eth_tx_pkt_fifo.sv
// Directed + random bench for eth_tx_pkt_fifo with a beat scoreboard.
module tb_eth_tx_pkt_fifo;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int LW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic resetn;
    logic [DW-1:0] in_tdata;
    logic in_tlast, in_tvalid, in_tready;
    logic [DW-1:0] out_tdata;
    logic out_tlast, out_tvalid, out_tready;
    logic [LW-1:0] fifo_level, pkt_count;
`ifdef TX_FIFO_STATS_EN
    logic [31:0] stat_frames_in, stat_frames_out, stat_cut_thru;
`endif

    eth_tx_pkt_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .axis_in_tdata(in_tdata), .axis_in_tlast(in_tlast),
        .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready),
        .axis_out_tdata(out_tdata), .axis_out_tlast(out_tlast),
        .axis_out_tvalid(out_tvalid), .axis_out_tready(out_tready),
        .fifo_level(fifo_level), .pkt_count(pkt_count)
`ifdef TX_FIFO_STATS_EN
        , .stat_frames_in(stat_frames_in), .stat_frames_out(stat_frames_out),
        .stat_cut_thru(stat_cut_thru)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [DW:0] sb[$];
    int n_fin = 0, n_fout = 0;
    bit rand_rdy = 0, rand_vld = 0;
    logic prev_v = 0, prev_r = 0;
    logic [DW:0] prev_d = '0;
    logic [DW-1:0] seq = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard push/pop and tvalid-hold protocol check.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_v <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_tvalid", 64'(out_tvalid), 64'd1);
                chk("hold_tdata", 64'({out_tlast, out_tdata}), 64'(prev_d));
            end
            if (out_tvalid && out_tready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) chk("sb_beat", 64'({out_tlast, out_tdata}), 64'(sb.pop_front()));
                if (out_tlast) n_fout++;
            end
            if (in_tvalid && in_tready) begin
                sb.push_back({in_tlast, in_tdata});
                if (in_tlast) n_fin++;
            end
            prev_v <= out_tvalid;
            prev_r <= out_tready;
            prev_d <= {out_tlast, out_tdata};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_tready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int n = 0;
        if (rand_vld) while ($urandom_range(0, 1) == 1) tick();
        in_tdata = d;
        in_tlast = last;
        in_tvalid = 1'b1;
        while (!in_tready && n < 500) begin tick(); n++; end
        if (n >= 500) chk("in_tready_timeout", 64'(in_tready), 64'd1);
        tick();
        in_tvalid = 1'b0;
        in_tlast = 1'b0;
    endtask

    task automatic send_frame(input int len);
        for (int b = 0; b < len; b++) begin
            send_beat(seq, 1'(b == len - 1));
            seq++;
        end
    endtask

    task automatic drain();
        int n = 0;
        out_tready = 1'b1;
        while ((fifo_level != 0 || out_tvalid) && n < 4000) begin tick(); n++; end
        chk("drain_level", 64'(fifo_level), 64'd0);
        chk("drain_pkts", 64'(pkt_count), 64'd0);
    endtask

    initial begin
        resetn = 1'b0;
        in_tdata = '0; in_tlast = 1'b0; in_tvalid = 1'b0; out_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_pkts", 64'(pkt_count), 64'd0);
        chk("rst_in_tready", 64'(in_tready), 64'd0);
        resetn = 1'b1;
        #1;
        chk("in_tready_before_edge", 64'(in_tready), 64'd0);
        @(posedge clk); #1;
        chk("in_tready_after_edge", 64'(in_tready), 64'd1);

        // 1-beat frame latency
        send_beat(32'hA5, 1'b1);
        chk("t1_tvalid_n", 64'(out_tvalid), 64'd0);
        chk("t1_pkts_1", 64'(pkt_count), 64'd1);
        chk("t1_level_1", 64'(fifo_level), 64'd1);
        tick();
        chk("t1_tvalid_n1", 64'(out_tvalid), 64'd1);
        chk("t1_tdata", 64'(out_tdata), 64'hA5);
        out_tready = 1'b1;
        tick();
        chk("t1_pkts_0", 64'(pkt_count), 64'd0);
        chk("t1_tvalid_off", 64'(out_tvalid), 64'd0);

        // 4-beat frame with a source stall before tlast
        for (int b = 0; b < 3; b++) begin send_beat(seq, 1'b0); seq++; end
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_back", 64'(out_tvalid), 64'd0);
            tick();
        end
        send_beat(seq, 1'b1); seq++;
        chk("t2_tvalid_n", 64'(out_tvalid), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_b2b", 64'(out_tvalid), 64'd1);
            tick();
        end
        chk("t2_done", 64'(out_tvalid), 64'd0);
        chk("t2_level", 64'(fifo_level), 64'd0);

        // fill with DEPTH 1-beat frames
        out_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_frame(1);
        chk("t3_in_tready_full", 64'(in_tready), 64'd0);
        chk("t3_pkts_full", 64'(pkt_count), 64'(DEPTH));
        chk("t3_level_full", 64'(fifo_level), 64'(DEPTH));
        drain();

        // oversize frame -> cut-through, then store-and-forward again
        out_tready = 1'b1;
        for (int b = 0; b < DEPTH; b++) begin send_beat(seq, 1'b0); seq++; end
        chk("t4_full_tready", 64'(in_tready), 64'd0);
        chk("t4_full_pkts", 64'(pkt_count), 64'd0);
        chk("t4_full_level", 64'(fifo_level), 64'(DEPTH));
        for (int b = 0; b < 8; b++) begin send_beat(seq, 1'(b == 7)); seq++; end
        drain();
        for (int b = 0; b < 2; b++) begin send_beat(seq, 1'b0); seq++; end
        for (int i = 0; i < 3; i++) begin
            chk("t4_sf_again", 64'(out_tvalid), 64'd0);
            tick();
        end
        send_beat(seq, 1'b1); seq++;
        drain();

        // random valid/ready
        rand_rdy = 1; rand_vld = 1;
        for (int f = 0; f < 1000; f++) send_frame(int'($urandom_range(1, DEPTH / 2)));
        rand_rdy = 0; rand_vld = 0;
        tick();
        drain();
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        chk("t5_frames_bal", 64'(n_fout), 64'(n_fin));
`ifdef TX_FIFO_STATS_EN
        chk("st_in", 64'(stat_frames_in), 64'(n_fin));
        chk("st_out", 64'(stat_frames_out), 64'(n_fout));
        chk("st_cut", 64'(stat_cut_thru), 64'd1);
`endif

        // reset mid-frame
        out_tready = 1'b0;
        send_frame(1);
        tick();
        chk("t6_tvalid_pre", 64'(out_tvalid), 64'd1);
        for (int b = 0; b < 2; b++) begin send_beat(seq, 1'b0); seq++; end
        resetn = 1'b0;
        #1;
        chk("t6_tvalid", 64'(out_tvalid), 64'd0);
        chk("t6_level", 64'(fifo_level), 64'd0);
        chk("t6_pkts", 64'(pkt_count), 64'd0);
        chk("t6_in_tready", 64'(in_tready), 64'd0);
`ifdef TX_FIFO_STATS_EN
        chk("t6_st_in", 64'(stat_frames_in), 64'd0);
        chk("t6_st_out", 64'(stat_frames_out), 64'd0);
        chk("t6_st_cut", 64'(stat_cut_thru), 64'd0);
`endif
        sb.delete();
        tick();
        resetn = 1'b1;
        tick();
        send_frame(3);
        drain();
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
